// File: rtl/fpdiv_ctrl.sv
// Sequencer for the iterative FP divide / square-root datapath.
// Walks one operation through INIT, the Goldschmidt ITER passes, the REM pass,
// ROUND and DONE. Special operands skip the multiplier and go through SPECIAL.
// All outputs are registered. Each one is decoded from the next state, so it
// lines up with the state it describes and clears at once on reset.

module fpdiv_ctrl_chk (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       accept,
    input  logic [3:0] n_calc,
    input  logic       ld_ops,
    input  logic       ld_iter,
    input  logic       ld_rem,
    input  logic       ld_q
);

    // iter_cnt is only three bits wide, so the iteration count must fit in it.
    a_n_fits: assert property (@(posedge clk) disable iff (!reset_n)
        accept |-> (n_calc <= 4'd7));

    // No more than one register-load strobe may be high in a cycle.
    a_strobe_excl: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({ld_ops, ld_iter, ld_rem, ld_q}));

endmodule

module fpdiv_ctrl #(
    parameter int DP_ITERS = 3,
    parameter int SP_ITERS = 2,
    parameter int MUL_LAT  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       op_sqrt,
    input  logic       P,
    input  logic [2:0] sel_inv,
    input  logic       flush,
    input  logic       ready_out,
    output logic       busy,
    output logic       ld_ops,
    output logic       ld_iter,
    output logic [1:0] mul_sel,
    output logic       ld_rem,
    output logic       ld_q,
    output logic [2:0] iter_cnt,
    output logic       P_q,
    output logic       sqrt_q,
    output logic       done
);

    localparam int STEP_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_ITER    = 3'd2,
        S_REM     = 3'd3,
        S_ROUND   = 3'd4,
        S_SPECIAL = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [STEP_W-1:0] step_cnt_r, step_cnt_s;
    logic [2:0]        iter_cnt_r, iter_cnt_s;
    logic [3:0]        n_r, n_s;
    logic              p_q_r, p_q_s;
    logic              sqrt_q_r, sqrt_q_s;

    logic              busy_r, busy_s;
    logic              ld_ops_r, ld_ops_s;
    logic              ld_iter_r, ld_iter_s;
    logic [1:0]        mul_sel_r, mul_sel_s;
    logic              ld_rem_r, ld_rem_s;
    logic              ld_q_r, ld_q_s;
    logic              done_r, done_s;

    logic              accept_s;
    logic [3:0]        n_calc_s;
    logic [3:0]        iter_inc_s;

    // Request acceptance and the iteration count; square root needs one extra pass.
    always_comb begin
        accept_s   = (state_r == S_IDLE) && start && !flush;
        n_calc_s   = (P ? 4'(SP_ITERS) : 4'(DP_ITERS)) + {3'b000, op_sqrt};
        iter_inc_s = {1'b0, iter_cnt_r} + 4'd1;
    end

    // Next state, counters and latched operation attributes.
    always_comb begin
        state_s    = state_r;
        step_cnt_s = step_cnt_r;
        iter_cnt_s = iter_cnt_r;
        n_s        = n_r;
        p_q_s      = p_q_r;
        sqrt_q_s   = sqrt_q_r;
        if ((state_r != S_IDLE) && flush) begin
            // Abort: the partial result is dropped. P_q/sqrt_q stay as they are.
            state_s    = S_IDLE;
            step_cnt_s = '0;
            iter_cnt_s = 3'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        p_q_s      = P;
                        sqrt_q_s   = op_sqrt;
                        n_s        = n_calc_s;
                        step_cnt_s = '0;
                        iter_cnt_s = 3'd0;
                        state_s    = (sel_inv != 3'b000) ? S_SPECIAL : S_INIT;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_INIT: begin
                    step_cnt_s = '0;
                    iter_cnt_s = 3'd0;
                    state_s    = S_ITER;
                end
                S_ITER: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_s = '0;
                        iter_cnt_s = iter_inc_s[2:0];
                        state_s    = (iter_inc_s == n_r) ? S_REM : S_ITER;
                    end else begin
                        step_cnt_s = step_cnt_r + STEP_W'(1);
                    end
                end
                S_REM: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_s = '0;
                        state_s    = S_ROUND;
                    end else begin
                        step_cnt_s = step_cnt_r + STEP_W'(1);
                    end
                end
                S_ROUND: begin
                    state_s = S_DONE;
                end
                S_SPECIAL: begin
                    state_s = S_DONE;
                end
                S_DONE: begin
                    if (ready_out) begin
                        state_s    = S_IDLE;
                        step_cnt_s = '0;
                        iter_cnt_s = 3'd0;
                    end else begin
                        state_s = S_DONE;
                    end
                end
                default: begin
                    state_s    = S_IDLE;
                    step_cnt_s = '0;
                    iter_cnt_s = 3'd0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        busy_s    = (state_s != S_IDLE);
        ld_ops_s  = (state_s == S_INIT);
        ld_iter_s = (state_s == S_ITER) && (step_cnt_s == STEP_LAST);
        ld_rem_s  = (state_s == S_REM) && (step_cnt_s == STEP_LAST);
        ld_q_s    = (state_s == S_ROUND) || (state_s == S_SPECIAL);
        done_s    = (state_s == S_DONE);
        case (state_s)
            S_INIT:  mul_sel_s = 2'b01;
            S_ITER:  mul_sel_s = 2'b10;
            S_REM:   mul_sel_s = 2'b11;
            default: mul_sel_s = 2'b00;
        endcase
    end

    // State, counter and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            step_cnt_r <= '0;
            iter_cnt_r <= 3'd0;
            n_r        <= 4'd0;
            p_q_r      <= 1'b0;
            sqrt_q_r   <= 1'b0;
            busy_r     <= 1'b0;
            ld_ops_r   <= 1'b0;
            ld_iter_r  <= 1'b0;
            mul_sel_r  <= 2'b00;
            ld_rem_r   <= 1'b0;
            ld_q_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            step_cnt_r <= step_cnt_s;
            iter_cnt_r <= iter_cnt_s;
            n_r        <= n_s;
            p_q_r      <= p_q_s;
            sqrt_q_r   <= sqrt_q_s;
            busy_r     <= busy_s;
            ld_ops_r   <= ld_ops_s;
            ld_iter_r  <= ld_iter_s;
            mul_sel_r  <= mul_sel_s;
            ld_rem_r   <= ld_rem_s;
            ld_q_r     <= ld_q_s;
            done_r     <= done_s;
        end
    end

    assign busy     = busy_r;
    assign ld_ops   = ld_ops_r;
    assign ld_iter  = ld_iter_r;
    assign mul_sel  = mul_sel_r;
    assign ld_rem   = ld_rem_r;
    assign ld_q     = ld_q_r;
    assign iter_cnt = iter_cnt_r;
    assign P_q      = p_q_r;
    assign sqrt_q   = sqrt_q_r;
    assign done     = done_r;

    fpdiv_ctrl_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .accept  (accept_s),
        .n_calc  (n_calc_s),
        .ld_ops  (ld_ops_r),
        .ld_iter (ld_iter_r),
        .ld_rem  (ld_rem_r),
        .ld_q    (ld_q_r)
    );

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench for fpdiv_ctrl. A timeline model works out the expected
// outputs from the cycles elapsed since accept. Directed sequences pin the
// key cycle numbers with literal values.

module tb_fpdiv_ctrl;

    localparam int DP_ITERS = 3;
    localparam int SP_ITERS = 2;
    localparam int MUL_LAT  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       op_sqrt = 1'b0;
    logic       P = 1'b0;
    logic [2:0] sel_inv = 3'b000;
    logic       flush = 1'b0;
    logic       ready_out = 1'b0;
    logic       busy, ld_ops, ld_iter, ld_rem, ld_q, P_q, sqrt_q, done;
    logic [1:0] mul_sel;
    logic [2:0] iter_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fpdiv_ctrl #(.DP_ITERS(DP_ITERS), .SP_ITERS(SP_ITERS), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_sqrt(op_sqrt), .P(P),
        .sel_inv(sel_inv), .flush(flush), .ready_out(ready_out), .busy(busy),
        .ld_ops(ld_ops), .ld_iter(ld_iter), .mul_sel(mul_sel), .ld_rem(ld_rem),
        .ld_q(ld_q), .iter_cnt(iter_cnt), .P_q(P_q), .sqrt_q(sqrt_q), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int m_busy, m_t, m_n, m_special, m_p, m_sqrt;
    int e_busy, e_ld_ops, e_ld_iter, e_ld_rem, e_ld_q, e_done, e_mul, e_iter;
    int iter_end, rem_end;

    always @* begin
        e_busy = m_busy; e_ld_ops = 0; e_ld_iter = 0; e_ld_rem = 0; e_ld_q = 0;
        e_done = 0; e_mul = 0; e_iter = 0;
        iter_end = 1 + m_n * MUL_LAT;
        rem_end  = 1 + (m_n + 1) * MUL_LAT;
        if (m_busy != 0) begin
            if (m_special != 0) begin
                e_ld_q = (m_t == 1) ? 1 : 0;
                e_done = (m_t >= 2) ? 1 : 0;
            end else if (m_t == 1) begin
                e_ld_ops = 1; e_mul = 1;
            end else if (m_t <= iter_end) begin
                e_mul = 2; e_iter = (m_t - 2) / MUL_LAT;
                e_ld_iter = ((m_t - 1) % MUL_LAT == 0) ? 1 : 0;
            end else if (m_t <= rem_end) begin
                e_mul = 3; e_iter = m_n;
                e_ld_rem = (m_t == rem_end) ? 1 : 0;
            end else begin
                e_iter = m_n;
                e_ld_q = (m_t == rem_end + 1) ? 1 : 0;
                e_done = (m_t > rem_end + 1) ? 1 : 0;
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_t <= 0; m_n <= 0; m_special <= 0; m_p <= 0; m_sqrt <= 0;
        end else if (m_busy == 0) begin
            if (start && !flush) begin
                m_busy    <= 1;
                m_t       <= 1;
                m_n       <= (P ? SP_ITERS : DP_ITERS) + int'(op_sqrt);
                m_special <= (sel_inv != 3'b000) ? 1 : 0;
                m_p       <= int'(P);
                m_sqrt    <= int'(op_sqrt);
            end
        end else if (flush || (e_done != 0 && ready_out)) begin
            m_busy <= 0; m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), e_busy);
        chk("ld_ops", int'(ld_ops), e_ld_ops);
        chk("ld_iter", int'(ld_iter), e_ld_iter);
        chk("ld_rem", int'(ld_rem), e_ld_rem);
        chk("ld_q", int'(ld_q), e_ld_q);
        chk("done", int'(done), e_done);
        chk("mul_sel", int'(mul_sel), e_mul);
        chk("iter_cnt", int'(iter_cnt), e_iter);
        chk("P_q", int'(P_q), m_p);
        chk("sqrt_q", int'(sqrt_q), m_sqrt);
    end

    // ---------------- directed stimulus ----------------
    int iq[$];
    int ic[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from accept (cycle 0) back to IDLE and records strobe cycles.
    task automatic run_op(input logic p, input logic sq, input logic [2:0] inv, input int hold,
                          output int c_ops, output int c_rem, output int c_q,
                          output int c_done, output int c_idle, output int n_done);
        int cyc;
        c_ops = -1; c_rem = -1; c_q = -1; c_done = -1; c_idle = -1; n_done = 0;
        iq.delete(); ic.delete();
        P = p; op_sqrt = sq; sel_inv = inv; flush = 1'b0; ready_out = 1'b1; start = 1'b1;
        cyc = 0;
        while (1) begin
            step();
            cyc++;
            start = 1'b0; ready_out = 1'b1;
            // Flip the request attributes: the latched copies must not follow them.
            P = ~p; op_sqrt = ~sq; sel_inv = 3'b000;
            if (ld_ops && c_ops < 0) c_ops = cyc;
            if (ld_iter) begin iq.push_back(cyc); ic.push_back(int'(iter_cnt)); end
            if (ld_rem) c_rem = cyc;
            if (ld_q) c_q = cyc;
            if (done) begin
                if (c_done < 0) c_done = cyc;
                n_done++;
                if (cyc - c_done < hold) ready_out = 1'b0;
                // A start while in DONE (including the release cycle) is ignored.
                if (cyc - c_done == 1 || cyc - c_done == hold) start = 1'b1;
            end
            if (!busy) begin c_idle = cyc; break; end
            if (cyc >= 200) begin chk("op_timeout", cyc, -1); break; end
        end
        step();
        chk("stay_idle", int'(busy), 0);
    endtask

    int c_ops, c_rem, c_q, c_done, c_idle, n_done;
    int exp_iq[3] = '{3, 5, 7};

    task automatic check_nominal(input string tag);
        chk({tag, "_ld_ops_cyc"}, c_ops, 1);
        chk({tag, "_n_ld_iter"}, iq.size(), 3);
        for (int i = 0; i < iq.size() && i < 3; i++) begin
            chk({tag, "_ld_iter_cyc"}, iq[i], exp_iq[i]);
            chk({tag, "_ld_iter_idx"}, ic[i], i);
        end
        chk({tag, "_ld_rem_cyc"}, c_rem, 9);
        chk({tag, "_ld_q_cyc"}, c_q, 10);
        chk({tag, "_done_cyc"}, c_done, 11);
    endtask

    initial begin
        #22 reset_n = 1'b1;
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mul_sel", int'(mul_sel), 0);
        chk("rst_iter_cnt", int'(iter_cnt), 0);
        chk("rst_P_q", int'(P_q), 0);

        // DP divide, downstream ready at once.
        run_op(1'b0, 1'b0, 3'b000, 0, c_ops, c_rem, c_q, c_done, c_idle, n_done);
        check_nominal("dp");
        chk("dp_idle_cyc", c_idle, 12);

        // SP square root: N = 2 + 1, same timing.
        run_op(1'b1, 1'b1, 3'b000, 0, c_ops, c_rem, c_q, c_done, c_idle, n_done);
        check_nominal("spsqrt");
        chk("spsqrt_idle_cyc", c_idle, 12);
        chk("spsqrt_P_q_held", int'(P_q), 1);
        chk("spsqrt_sqrt_q_held", int'(sqrt_q), 1);

        // Divide by zero takes the special path.
        run_op(1'b0, 1'b0, 3'b110, 0, c_ops, c_rem, c_q, c_done, c_idle, n_done);
        chk("spec_ld_q_cyc", c_q, 1);
        chk("spec_done_cyc", c_done, 2);
        chk("spec_idle_cyc", c_idle, 3);
        chk("spec_no_ld_ops", c_ops, -1);
        chk("spec_no_ld_iter", iq.size(), 0);
        chk("spec_no_ld_rem", c_rem, -1);

        // DP divide with downstream back-pressure for 4 cycles.
        run_op(1'b0, 1'b0, 3'b000, 4, c_ops, c_rem, c_q, c_done, c_idle, n_done);
        chk("bp_done_cyc", c_done, 11);
        chk("bp_done_len", n_done, 5);
        chk("bp_idle_cyc", c_idle, 16);

        // Flush mid-ITER at cycle 5, then restart at cycle 6.
        P = 1'b0; op_sqrt = 1'b0; sel_inv = 3'b000; ready_out = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 2; i <= 5; i++) step();
        chk("fl_busy_c5", int'(busy), 1);
        flush = 1'b1;
        step(); flush = 1'b0;
        chk("fl_busy_c6", int'(busy), 0);
        chk("fl_no_ld_q", int'(ld_q), 0);
        chk("fl_no_ld_rem", int'(ld_rem), 0);
        chk("fl_no_done", int'(done), 0);
        run_op(1'b0, 1'b0, 3'b000, 0, c_ops, c_rem, c_q, c_done, c_idle, n_done);
        check_nominal("fl_restart");

        // Flush wins over start in IDLE.
        start = 1'b1; flush = 1'b1;
        step(); start = 1'b0; flush = 1'b0;
        chk("fl_idle_no_accept", int'(busy), 0);

        // Asynchronous reset mid-ITER at cycle 4.
        P = 1'b1; op_sqrt = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 2; i <= 4; i++) step();
        chk("ar_busy_before", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_busy", int'(busy), 0);
        chk("ar_mul_sel", int'(mul_sel), 0);
        chk("ar_iter_cnt", int'(iter_cnt), 0);
        chk("ar_ld_iter", int'(ld_iter), 0);
        chk("ar_P_q", int'(P_q), 0);
        chk("ar_sqrt_q", int'(sqrt_q), 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();
        run_op(1'b0, 1'b0, 3'b000, 0, c_ops, c_rem, c_q, c_done, c_idle, n_done);
        check_nominal("ar_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
Sequencer for the iterative floating-point divide/square-root datapath. It accepts one operation at a time and steps the shared multiplier through the Goldschmidt iterations and the remainder pass. It then strobes the register loads that present q/qm/qp candidates and the remainder to the divide rounder, and holds the result until the downstream stage accepts it. Special cases indicated by sel_inv bypass the iterations.

Parameters:
DP_ITERS, 3, Goldschmidt iterations for double-precision divide
SP_ITERS, 2, Goldschmidt iterations for single-precision divide
MUL_LAT, 2, cycles per multiplier pass (>=1)

Ports:
clk  in  1  clock; all state changes on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  request; accepted only in IDLE
op_sqrt  in  1  1 = square root, 0 = divide; sampled at accept
P  in  1  precision, 1 = single, 0 = double; sampled at accept
sel_inv  in  3  special-case code; nonzero = bypass iterations; sampled at accept
flush  in  1  abort current operation
ready_out  in  1  downstream accepts result
busy  out  1  state != IDLE
ld_ops  out  1  load operand/initial-estimate registers (INIT)
ld_iter  out  1  load iterate registers (last cycle of each ITER pass)
mul_sel  out  2  multiplier operand select: 00 idle, 01 init, 10 iterate, 11 remainder
ld_rem  out  1  load remainder register (regr) (last REM cycle)
ld_q  out  1  load q/qm/qp candidate registers (ROUND)
iter_cnt  out  3  current iteration index, 0-based
P_q  out  1  latched precision
sqrt_q  out  1  latched op_sqrt
done  out  1  result valid to rounder/writeback

Behaviour:
- Reset (reset_n=0, any time, asynchronous): state=IDLE. All outputs 0, including P_q, sqrt_q, iter_cnt and mul_sel. Internal counters 0.
- N = (P ? SP_ITERS : DP_ITERS) + op_sqrt. The sqrt adds one iteration. N is computed at accept from sampled values.
- States: IDLE, INIT, ITER, REM, ROUND, SPECIAL, DONE.
- IDLE: start=1 and flush=0 -> accept. Latch P_q, sqrt_q and N. sel_inv!=0 -> SPECIAL, else INIT. start while busy is ignored, with no queueing.
- INIT (1 cycle): ld_ops=1, mul_sel=01. Clear step_cnt and iter_cnt. Next state is ITER.
- ITER: mul_sel=10. step_cnt counts 0..MUL_LAT-1.
  - ld_iter=1 only when step_cnt==MUL_LAT-1. On that cycle step_cnt clears and iter_cnt increments.
  - After iteration N-1 completes -> REM.
- REM (MUL_LAT cycles): mul_sel=11. ld_rem=1 on the last cycle. Next state is ROUND.
- ROUND (1 cycle): ld_q=1, mul_sel=00. Next state is DONE.
- SPECIAL (1 cycle): ld_q=1, no multiplier activity. Next state is DONE.
- DONE: done=1, and it stays high until ready_out=1. done & ready_out -> IDLE next cycle, with done=0 in IDLE. A start in that same cycle is ignored.
- Latency: the accept cycle is cycle 0.
  - Normal path: INIT at cycle 1, ITER at cycles 2..1+N*MUL_LAT, REM follows, ROUND at cycle 2+(N+1)*MUL_LAT, done first high at cycle 3+(N+1)*MUL_LAT.
  - Special path: done first high at cycle 2.
- flush=1 in any non-IDLE state -> IDLE next edge. All strobes are 0 in the cycle after. Counters clear. The partial result is discarded and no done is produced.
- flush in IDLE with start=1: flush wins and the request is not accepted.
- Strobes are single-cycle and mutually exclusive. At most one of ld_ops, ld_iter, ld_rem, ld_q is high per cycle.
- P_q and sqrt_q hold from accept through DONE. They return to 0 only on reset; flush does not change them.
- iter_cnt is 3 bits and saturation is not needed: N <= 4 at defaults. An implementation must flag (assertion) N > 7.

Test Plan:
- DP divide (P=0, op_sqrt=0, sel_inv=0), start pulse, ready_out=1 -> N=3. ld_ops at cycle 1. ld_iter at cycles 3,5,7 with iter_cnt 0,1,2. ld_rem at cycle 9, ld_q at cycle 10, done at cycle 11, busy low at cycle 12.
- SP sqrt (P=1, op_sqrt=1) -> N=3. Same timing as the previous case, with P_q=1 and sqrt_q=1 throughout.
- sel_inv=3'b110 (div by zero) -> SPECIAL at cycle 1 with ld_q=1, done at cycle 2. ld_ops, ld_iter and ld_rem never assert.
- DP divide with ready_out=0 for 4 cycles after done -> done held high for cycles 11..15. Return to IDLE only after ready_out=1. A start pulse during DONE is ignored.
- flush at cycle 5 of a DP divide -> IDLE at cycle 6. No ld_rem, ld_q or done occurs. A new start at cycle 6 is accepted and the full operation completes normally.
- reset_n low at cycle 4 mid-ITER (asynchronous, between edges) -> all outputs 0 immediately. After release, start is accepted in IDLE and the operation completes with nominal latency.
